// File: rtl/window_max.sv
// Windowed max/min reducer: each accepted pair contributes the larger of its two
// operands; a window closes after WIN pairs or on flush and is held until consumed.
module window_max #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned WIN   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [7:0]       out_cnt,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] WIN_C = 8'(WIN);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] sel;
    logic             accept;

    assign in_ready = (state_q != HOLD);
    assign accept   = in_valid && in_ready;
    assign sel      = (in_a > in_b) ? in_a : in_b;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        min_d   = min_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    max_d   = sel;
                    min_d   = sel;
                    cnt_d   = 8'd1;
                    state_d = flush ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (sel > max_q) max_d = sel;
                    if (sel < min_q) min_d = sel;
                    cnt_d = cnt_q + 8'd1;
                end
                // The pair accepted this cycle is folded in before the window closes
                if (flush || (accept && (cnt_q + 8'd1 == WIN_C))) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    max_d   = '0;
                    min_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                max_d   = '0;
                min_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            max_q   <= '0;
            min_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            min_q   <= min_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_max   = out_valid ? max_q : '0;
    assign out_min   = out_valid ? min_q : '0;
    assign out_cnt   = out_valid ? cnt_q : '0;

endmodule

// File: tb/tb_window_max.sv
// Scoreboard bench for window_max: a queue-based window model predicts each closed
// window; a negedge monitor compares whatever the DUT presents against the queue head.
module tb_window_max;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned WIN   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_a, in_b;
    logic             in_valid, in_ready, flush;
    logic [WIDTH-1:0] out_max, out_min;
    logic [7:0]       out_cnt;
    logic             out_valid, out_ready;

    window_max #(.WIDTH(WIDTH), .WIN(WIN)) dut (
        .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_max(out_max), .out_min(out_min),
        .out_cnt(out_cnt), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] mx;
        logic [WIDTH-1:0] mn;
        logic [7:0]       cnt;
    } res_t;

    res_t             exp_q[$];
    logic [WIDTH-1:0] win_q[$];
    bit               m_held;
    bit               mon_en;
    int unsigned      errors, checks;
    int unsigned      accepted_sum, popped_sum;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Called just after a rising edge: drive one cycle of inputs, predict the edge.
    task automatic step(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input bit fl, input bit ordy, input bit r);
        res_t r_item;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        flush     = fl;
        out_ready = ordy;
        rst       = r;
        chk("in_ready", in_ready, !m_held);
        if (r) begin
            win_q.delete();
            exp_q.delete();
            m_held = 0;
        end else if (m_held) begin
            if (ordy) m_held = 0;
        end else begin
            if (v) begin
                win_q.push_back((a > b) ? a : b);
                accepted_sum++;
            end
            if (win_q.size() == WIN || (fl && win_q.size() > 0)) begin
                r_item.mx  = win_q[0];
                r_item.mn  = win_q[0];
                r_item.cnt = 8'(win_q.size());
                foreach (win_q[i]) begin
                    if (win_q[i] > r_item.mx) r_item.mx = win_q[i];
                    if (win_q[i] < r_item.mn) r_item.mn = win_q[i];
                end
                exp_q.push_back(r_item);
                win_q.delete();
                m_held = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    chk("out_max", out_max, exp_q[0].mx);
                    chk("out_min", out_min, exp_q[0].mn);
                    chk("out_cnt", out_cnt, exp_q[0].cnt);
                    if (out_ready) begin
                        popped_sum += out_cnt;
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk("idle_outputs_zero", {out_max, out_min, out_cnt}, 32'd0);
            end
        end
    end

    initial begin
        errors = 0; checks = 0; m_held = 0; mon_en = 0;
        accepted_sum = 0; popped_sum = 0;
        rst = 1; in_valid = 0; in_a = '0; in_b = '0; flush = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_outputs", {out_max, out_min, out_cnt}, 0);
        chk("reset_in_ready", in_ready, 1);
        mon_en = 1;
        step(0, 0, 0, 0, 0, 0);

        // Full window with consumer always ready
        step(1, 3, 9, 0, 1, 0);
        step(1, 12, 5, 0, 1, 0);
        step(1, 7, 7, 0, 1, 0);
        step(1, 1, 2, 0, 1, 0);
        chk("w4_valid", out_valid, 1);
        chk("w4_max", out_max, 12);
        chk("w4_min", out_min, 2);
        chk("w4_cnt", out_cnt, 4);
        step(0, 0, 0, 0, 1, 0);
        chk("w4_back_idle", out_valid, 0);

        // Back-pressure: pairs offered while holding must not be absorbed
        step(1, 10, 20, 0, 0, 0);
        step(1, 30, 5, 0, 0, 0);
        step(1, 8, 8, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 8'd99, 8'd250, 1, 0, 0);
        chk("hold_valid", out_valid, 1);
        chk("hold_max", out_max, 30);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        // Flush with a pair in the same cycle
        step(1, 200, 100, 0, 0, 0);
        step(1, 50, 60, 0, 0, 0);
        step(1, 255, 0, 1, 0, 0);
        chk("flush_max", out_max, 255);
        chk("flush_min", out_min, 60);
        chk("flush_cnt", out_cnt, 3);
        step(0, 0, 0, 0, 1, 0);

        // Flush alone in IDLE is ignored
        step(0, 0, 0, 1, 1, 0);
        chk("idle_flush_valid", out_valid, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("idle_flush_valid2", out_valid, 0);

        // Flush with a single pair in IDLE closes a one-pair window
        step(1, 4, 40, 1, 0, 0);
        chk("single_cnt", out_cnt, 1);
        chk("single_max", out_max, 40);
        step(0, 0, 0, 0, 1, 0);

        // Reset discards a partial window, taking priority over valid/flush
        step(1, 250, 240, 0, 1, 0);
        step(1, 230, 220, 0, 1, 0);
        step(1, 255, 255, 1, 1, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_max", out_max, 0);
        chk("post_rst_min", out_min, 0);
        chk("post_rst_cnt", out_cnt, 4);
        step(0, 0, 0, 0, 1, 0);

        // Random stress
        accepted_sum = 0;
        popped_sum   = 0;
        for (int unsigned cyc = 0; cyc < 60000 && accepted_sum < 10000; cyc++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 1) == 1), 0);
        end
        chk("stress_volume", 32'(accepted_sum >= 10000), 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("pairs_counted_once", popped_sum, accepted_sum);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
